// File: rtl/sprite_animator.sv
// Sprite engine: bouncing horizontal walk, frame animation, start/halt FSM, pixel hit + sheet address.
// Latency: motion 1 Clk after registered frame_clk rise; pixel path combinational. No backpressure.
// Optional SPRITE_MIRROR_EN: mirror sheet columns while moving left.
module sprite_animator #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int SHEET_W    = 256,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 10,
    parameter int X_MIN      = 1,
    parameter int X_MAX      = 575,
    parameter int X_START    = 320,
    parameter int Y_START    = 240,
    parameter int STEP       = 1,
    parameter int ADDR_W     = 14
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              start,
    input  logic              halt,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              is_sprite,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic              dir,
    output logic [1:0]        state
);

    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WALK  = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                fclk_q, fclk_prev_q;
    logic                tick;
    logic [9:0]          pos_x_q, pos_x_d;
    logic                dir_q, dir_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    // frame_clk is sampled once; the edge detect runs on the registered copy
    assign tick = fclk_q & ~fclk_prev_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!halt && start) state_d = ST_WALK;
            ST_WALK:  if (halt)           state_d = ST_PAUSE;
            ST_PAUSE: if (!halt && start) state_d = ST_WALK;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state = state_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fclk_q      <= 1'b0;
            fclk_prev_q <= 1'b0;
            pos_x_q     <= 10'(X_START);
            dir_q       <= 1'b0;
            frame_q     <= '0;
            hold_q      <= '0;
        end else begin
            fclk_q      <= frame_clk;
            fclk_prev_q <= fclk_q;
            pos_x_q     <= pos_x_d;
            dir_q       <= dir_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        pos_x_d = pos_x_q;
        dir_d   = dir_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        if (state_q == ST_IDLE) begin
            frame_d = '0;
            hold_d  = '0;
        end else if (state_q == ST_WALK && tick) begin
            // reversal and first step in the new direction share one tick
            if (!dir_q && pos_x_q >= 10'(X_MAX)) begin
                dir_d   = 1'b1;
                pos_x_d = pos_x_q - 10'(STEP);
            end else if (dir_q && pos_x_q <= 10'(X_MIN)) begin
                dir_d   = 1'b0;
                pos_x_d = pos_x_q + 10'(STEP);
            end else if (!dir_q) begin
                pos_x_d = pos_x_q + 10'(STEP);
            end else begin
                pos_x_d = pos_x_q - 10'(STEP);
            end

            if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                hold_d  = '0;
                frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                hold_d  = hold_q + 1'b1;
            end
        end
    end

    assign pos_x = pos_x_q;
    assign pos_y = 10'(Y_START);
    assign dir   = dir_q;

    logic [10:0]       dx, dy, col;
    logic              in_x, in_y;
    logic [ADDR_W-1:0] addr_full;

    // 11-bit compares keep pixels left of / above the box from wrapping into hits
    assign dx   = {1'b0, DrawX} - {1'b0, pos_x_q};
    assign dy   = {1'b0, DrawY} - {1'b0, pos_y};
    assign in_x = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
                  ({1'b0, DrawX} <  ({1'b0, pos_x_q} + 11'(SPR_W)));
    assign in_y = ({1'b0, DrawY} >= {1'b0, pos_y}) &&
                  ({1'b0, DrawY} <  ({1'b0, pos_y} + 11'(SPR_H)));
    assign is_sprite = in_x && in_y;

`ifdef SPRITE_MIRROR_EN
    assign col = dir_q ? (11'(SPR_W - 1) - dx) : dx;
`else
    assign col = dx;
`endif

    assign addr_full = ADDR_W'(dy) * ADDR_W'(SHEET_W)
                     + ADDR_W'(frame_q) * ADDR_W'(SPR_W)
                     + ADDR_W'(col);
    assign sprite_addr = is_sprite ? addr_full : '0;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: three instances (centre walk, right-limit bounce, tight-range bounce).
module tb_sprite_animator;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start_d = 1'b0, halt_d = 1'b0;
    logic        start_r = 1'b0, halt_r = 1'b0;
    logic        start_l = 1'b0, halt_l = 1'b0;
    logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;

    logic        is_d, is_r, is_l;
    logic [13:0] addr_d, addr_r, addr_l;
    logic [9:0]  px_d, px_r, px_l, py_d, py_r, py_l;
    logic        dir_d, dir_r, dir_l;
    logic [1:0]  st_d, st_r, st_l;

    int checks = 0;
    int fails  = 0;

    always #10 Clk = ~Clk;

    sprite_animator u_dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start_d), .halt(halt_d),
        .DrawX(DrawX), .DrawY(DrawY), .is_sprite(is_d), .sprite_addr(addr_d),
        .pos_x(px_d), .pos_y(py_d), .dir(dir_d), .state(st_d)
    );

    sprite_animator #(.X_START(574)) u_r (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start_r), .halt(halt_r),
        .DrawX(DrawX), .DrawY(DrawY), .is_sprite(is_r), .sprite_addr(addr_r),
        .pos_x(px_r), .pos_y(py_r), .dir(dir_r), .state(st_r)
    );

    sprite_animator #(.X_MIN(1), .X_MAX(3), .X_START(2)) u_l (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start_l), .halt(halt_l),
        .DrawX(DrawX), .DrawY(DrawY), .is_sprite(is_l), .sprite_addr(addr_l),
        .pos_x(px_l), .pos_y(py_l), .dir(dir_l), .state(st_l)
    );

    task automatic do_tick;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        halt_d = 1'b1;
        @(negedge Clk);
        halt_d = 1'b0;
        repeat (5) do_tick();
        #1;
        checks++; if (px_d !== 10'd320) begin fails++; $display("FAIL reset_pos_x got %0d exp 320", px_d); end
        checks++; if (py_d !== 10'd240) begin fails++; $display("FAIL reset_pos_y got %0d exp 240", py_d); end
        checks++; if (dir_d !== 1'b0) begin fails++; $display("FAIL reset_dir got %0d exp 0", dir_d); end
        checks++; if (st_d !== 2'b00) begin fails++; $display("FAIL reset_state got %0d exp 0", st_d); end
        checks++; if (px_r !== 10'd574) begin fails++; $display("FAIL reset_pos_x_r got %0d exp 574", px_r); end
        DrawX = 10'd320; DrawY = 10'd240; #1;
        checks++; if (is_d !== 1'b1) begin fails++; $display("FAIL corner_hit got %0d exp 1", is_d); end
        checks++; if (addr_d !== 14'd0) begin fails++; $display("FAIL corner_addr got %0d exp 0", addr_d); end
        DrawX = 10'd319; #1;
        checks++; if (is_d !== 1'b0) begin fails++; $display("FAIL left_miss got %0d exp 0", is_d); end
        checks++; if (addr_d !== 14'd0) begin fails++; $display("FAIL left_miss_addr got %0d exp 0", addr_d); end
        DrawX = 10'd320; DrawY = 10'd239; #1;
        checks++; if (is_d !== 1'b0) begin fails++; $display("FAIL above_miss got %0d exp 0", is_d); end
        DrawX = 10'd383; DrawY = 10'd303; #1;
        checks++; if (is_d !== 1'b1) begin fails++; $display("FAIL far_corner_hit got %0d exp 1", is_d); end
        checks++; if (addr_d !== 14'd16191) begin fails++; $display("FAIL far_corner_addr got %0d exp 16191", addr_d); end
        DrawX = 10'd384; #1;
        checks++; if (is_d !== 1'b0) begin fails++; $display("FAIL right_miss got %0d exp 0", is_d); end
        DrawX = 10'd383; DrawY = 10'd304; #1;
        checks++; if (is_d !== 1'b0) begin fails++; $display("FAIL below_miss got %0d exp 0", is_d); end
    endtask

    task automatic test_walk;
        @(negedge Clk); start_d = 1'b1;
        @(negedge Clk); start_d = 1'b0; #1;
        checks++; if (st_d !== 2'b01) begin fails++; $display("FAIL walk_state got %0d exp 1", st_d); end
        repeat (9) do_tick();
        DrawX = 10'd329; DrawY = 10'd240; #1;
        checks++; if (px_d !== 10'd329) begin fails++; $display("FAIL walk9_pos got %0d exp 329", px_d); end
        checks++; if (addr_d !== 14'd0) begin fails++; $display("FAIL walk9_frame_addr got %0d exp 0", addr_d); end
        do_tick();
        DrawX = 10'd330; DrawY = 10'd240; #1;
        checks++; if (px_d !== 10'd330) begin fails++; $display("FAIL walk10_pos got %0d exp 330", px_d); end
        checks++; if (addr_d !== 14'd64) begin fails++; $display("FAIL walk10_frame_addr got %0d exp 64", addr_d); end
        DrawX = 10'd331; DrawY = 10'd242; #1;
        checks++; if (addr_d !== 14'd577) begin fails++; $display("FAIL walk10_addr577 got %0d exp 577", addr_d); end
        @(negedge Clk); start_d = 1'b1;
        @(negedge Clk); start_d = 1'b0; #1;
        checks++; if (st_d !== 2'b01) begin fails++; $display("FAIL start_in_walk got %0d exp 1", st_d); end
        repeat (3) do_tick();
    endtask

    task automatic test_pause;
        @(negedge Clk); start_d = 1'b1; halt_d = 1'b1;
        @(negedge Clk); start_d = 1'b0; halt_d = 1'b0; #1;
        checks++; if (st_d !== 2'b10) begin fails++; $display("FAIL halt_wins got %0d exp 2", st_d); end
        repeat (20) do_tick();
        DrawX = 10'd333; DrawY = 10'd240; #1;
        checks++; if (px_d !== 10'd333) begin fails++; $display("FAIL pause_pos got %0d exp 333", px_d); end
        checks++; if (addr_d !== 14'd64) begin fails++; $display("FAIL pause_frame got %0d exp 64", addr_d); end
        checks++; if (st_d !== 2'b10) begin fails++; $display("FAIL pause_state got %0d exp 2", st_d); end
        @(negedge Clk); start_d = 1'b1;
        @(negedge Clk); start_d = 1'b0; #1;
        checks++; if (st_d !== 2'b01) begin fails++; $display("FAIL resume_state got %0d exp 1", st_d); end
        repeat (6) do_tick();
        DrawX = 10'd339; #1;
        checks++; if (px_d !== 10'd339) begin fails++; $display("FAIL resume6_pos got %0d exp 339", px_d); end
        checks++; if (addr_d !== 14'd64) begin fails++; $display("FAIL resume6_frame got %0d exp 64", addr_d); end
        do_tick();
        DrawX = 10'd340; #1;
        checks++; if (addr_d !== 14'd128) begin fails++; $display("FAIL resume7_frame got %0d exp 128", addr_d); end
    endtask

    task automatic test_bounce_right;
        logic [9:0] exp_pos [3];
        logic       exp_dir [3];
        exp_pos = '{10'd575, 10'd574, 10'd573};
        exp_dir = '{1'b0, 1'b1, 1'b1};
        @(negedge Clk); start_r = 1'b1;
        @(negedge Clk); start_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_tick(); #1;
            checks++; if (px_r !== exp_pos[i]) begin fails++; $display("FAIL bounce_r_pos[%0d] got %0d exp %0d", i, px_r, exp_pos[i]); end
            checks++; if (dir_r !== exp_dir[i]) begin fails++; $display("FAIL bounce_r_dir[%0d] got %0d exp %0d", i, dir_r, exp_dir[i]); end
        end
    endtask

    task automatic test_bounce_left;
        logic [9:0] exp_pos [5];
        logic       exp_dir [5];
        exp_pos = '{10'd3, 10'd2, 10'd1, 10'd2, 10'd3};
        exp_dir = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge Clk); start_l = 1'b1;
        @(negedge Clk); start_l = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_tick(); #1;
            checks++; if (px_l !== exp_pos[i]) begin fails++; $display("FAIL bounce_l_pos[%0d] got %0d exp %0d", i, px_l, exp_pos[i]); end
            checks++; if (dir_l !== exp_dir[i]) begin fails++; $display("FAIL bounce_l_dir[%0d] got %0d exp %0d", i, dir_l, exp_dir[i]); end
        end
    endtask

    task automatic test_frame_seq;
        int exp_frame;
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk); start_d = 1'b1;
        @(negedge Clk); start_d = 1'b0;
        DrawY = 10'd240;
        for (int t = 1; t <= 45; t++) begin
            do_tick();
            exp_frame = (t / 10) % 4;
            DrawX = px_d; #1;
            checks++; if (px_d !== 10'(320 + t)) begin fails++; $display("FAIL seq_pos[%0d] got %0d exp %0d", t, px_d, 320 + t); end
            checks++; if (addr_d !== 14'(exp_frame * 64)) begin fails++; $display("FAIL seq_frame_addr[%0d] got %0d exp %0d", t, addr_d, exp_frame * 64); end
        end
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0; #1;
        checks++; if (px_d !== 10'd320) begin fails++; $display("FAIL midreset_pos got %0d exp 320", px_d); end
        checks++; if (dir_d !== 1'b0) begin fails++; $display("FAIL midreset_dir got %0d exp 0", dir_d); end
        checks++; if (st_d !== 2'b00) begin fails++; $display("FAIL midreset_state got %0d exp 0", st_d); end
        checks++; if (px_r !== 10'd574) begin fails++; $display("FAIL midreset_pos_r got %0d exp 574", px_r); end
        do_tick(); #1;
        checks++; if (px_d !== 10'd320) begin fails++; $display("FAIL idle_after_reset_pos got %0d exp 320", px_d); end
    endtask

    task automatic test_mirror;
        logic [13:0] exp0, exp1;
`ifdef SPRITE_MIRROR_EN
        exp0 = 14'd63; exp1 = 14'd62;
`else
        exp0 = 14'd0;  exp1 = 14'd1;
`endif
        @(negedge Clk); start_l = 1'b1;
        @(negedge Clk); start_l = 1'b0;
        repeat (2) do_tick();
        DrawX = 10'd2; DrawY = 10'd240; #1;
        checks++; if (dir_l !== 1'b1) begin fails++; $display("FAIL mirror_dir got %0d exp 1", dir_l); end
        checks++; if (is_l !== 1'b1) begin fails++; $display("FAIL mirror_hit got %0d exp 1", is_l); end
        checks++; if (addr_l !== exp0) begin fails++; $display("FAIL mirror_addr_dx0 got %0d exp %0d", addr_l, exp0); end
        DrawX = 10'd3; #1;
        checks++; if (addr_l !== exp1) begin fails++; $display("FAIL mirror_addr_dx1 got %0d exp %0d", addr_l, exp1); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_pause();
        test_bounce_right();
        test_bounce_left();
        test_frame_seq();
        test_mirror();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
Parametrised sprite engine for Duck Hunt actors (dog, ducks), for sheets with a configurable frame count. Holds the sprite position and walks it horizontally, bouncing between two X limits. Cycles the animation frames at a programmable rate and adds a start/halt control state machine. Generates the per-pixel hit flag and the sprite-sheet ROM address for the colour mapper, combinationally from DrawX/DrawY.

Parameters:
SPR_W, 64, sprite frame width in pixels
SPR_H, 64, sprite frame height in pixels
SHEET_W, 256, sprite-sheet row pitch in pixels; NUM_FRAMES*SPR_W <= SHEET_W required
NUM_FRAMES, 4, animation frames laid side by side in the sheet, >= 1
FRAME_HOLD, 10, frame ticks each animation frame is shown, >= 1
X_MIN, 1, leftmost allowed pos_x
X_MAX, 575, rightmost allowed pos_x
X_START, 320, reset pos_x
Y_START, 240, reset pos_y
STEP, 1, pixels moved per frame tick, < X_MIN+1
ADDR_W, 14, sprite_addr width

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high
frame_clk  in  1  vertical-sync-rate strobe (~60 Hz), asynchronous to pixel grid
start  in  1  single-Clk pulse: begin or resume walking
halt  in  1  single-Clk pulse: freeze motion and animation
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_sprite  out  1  current pixel lies inside the sprite box
sprite_addr  out  ADDR_W  sheet ROM address for the current pixel
pos_x  out  10  sprite top-left X
pos_y  out  10  sprite top-left Y
dir  out  1  0 = moving right, 1 = moving left
state  out  2  00 IDLE, 01 WALK, 10 PAUSE

Behaviour:
- Reset (Clk edge with Reset=1, takes effect in any state, mid-walk included): pos_x=X_START, pos_y=Y_START, dir=0, frame=0, hold count=0, state=IDLE.
- Tick: frame_clk is registered once. tick=1 for exactly one Clk when the registered value goes 0->1. This gives 1 Clk of latency from the frame_clk rise and one tick per frame_clk period.
- State transitions are evaluated every Clk and take effect on the next edge.
  - IDLE: start -> WALK.
  - WALK: halt -> PAUSE.
  - PAUSE: start -> WALK.
  - halt in IDLE and start in WALK have no effect.
  - start and halt in the same cycle: halt wins (IDLE stays IDLE, WALK -> PAUSE, PAUSE stays PAUSE).
- Motion and animation on a tick use the state before that edge. A start arriving on the same cycle as a tick does not move the sprite on that tick.
- WALK on a tick:
  - If dir=0 and pos_x >= X_MAX: dir<=1, pos_x<=pos_x-STEP.
  - Else if dir=1 and pos_x <= X_MIN: dir<=0, pos_x<=pos_x+STEP.
  - Else: pos_x<=pos_x+STEP when dir=0, pos_x-STEP when dir=1.
  - A reversal and its first step in the new direction happen on the same tick. pos_x never leaves [X_MIN-STEP+1, X_MAX+STEP-1].
- Animation in WALK on a tick:
  - If hold=FRAME_HOLD-1: hold<=0 and frame advances, wrapping NUM_FRAMES-1 -> 0.
  - Else: hold<=hold+1.
  - With FRAME_HOLD=1 the frame advances every tick.
- IDLE: on entry and while resident, frame=0 and hold=0; position and dir hold.
- PAUSE: position, dir, frame and hold all frozen. Resuming continues from the frozen values.
- pos_y is constant (Y_START) in this generation.
- Pixel path, combinational (0 Clk):
  - dx=DrawX-pos_x, dy=DrawY-pos_y, computed 11-bit.
  - is_sprite=1 iff DrawX>=pos_x, DrawX<pos_x+SPR_W, DrawY>=pos_y and DrawY<pos_y+SPR_H. Pixels left of or above the sprite never alias as hits.
  - sprite_addr = dy*SHEET_W + frame*SPR_W + dx, truncated to ADDR_W, when is_sprite=1; 0 otherwise.

Optional Feature:
SPRITE_MIRROR_EN. When defined: while dir=1, the column term dx in sprite_addr is replaced by SPR_W-1-dx, so a sheet drawn facing right renders facing left. is_sprite is unaffected. When undefined: sprite_addr always uses dx, whatever dir is.

Test Plan:
- Reset, then idle 5 ticks -> pos_x=320, pos_y=240, dir=0, state=00; DrawX=320,DrawY=240 -> is_sprite=1, sprite_addr=0; DrawX=319 -> is_sprite=0, sprite_addr=0.
- start, then 10 ticks -> pos_x=330, frame advanced 0->1 exactly on tick 10; DrawX=331,DrawY=242 -> sprite_addr=2*256+64+1=577.
- X_START=574, start, 3 ticks -> pos_x 575, 574 with dir=1, then 573; a mirror for X_MIN bounce with X_START=2 -> pos_x 1, 2 with dir=0.
- WALK, halt with start on the same Clk -> state=PAUSE; 20 ticks -> pos_x and frame unchanged; start -> resumes from the frozen frame/hold.
- 45 ticks in WALK with FRAME_HOLD=10, NUM_FRAMES=4 -> frame sequence 0,1,2,3,0 changing on ticks 10,20,30,40; Reset asserted mid-walk -> all outputs return to reset values on the next edge.
- SPRITE_MIRROR_EN defined, dir=1, dx=0, dy=0, frame=0 -> sprite_addr=63; undefined -> sprite_addr=0.
